mem_copier: RTL and testbench

MEM_COPIER -- requirements
Module: mem_copier

---
 rtl/mem_copier.sv | 99 +++++++++
 tb/tb_mem_copier.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copier.sv
// Word-granular memory-to-memory copier: alternates one READ and one WRITE cycle per
// 32-bit word, ascending addresses, and accumulates a mod-2^32 checksum of the data moved.
module mem_copier #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic [31:0]      checksum,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_ptr_q, src_ptr_d;
  logic [31:0]      dst_ptr_q, dst_ptr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      checksum_q, checksum_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      src_ptr_q   <= '0;
      dst_ptr_q   <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      checksum_q  <= checksum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    checksum_d  = checksum_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wd      = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d   = {src_addr[31:2], 2'b00};
          dst_ptr_d   = {dst_addr[31:2], 2'b00};
          remaining_d = word_count;
          checksum_d  = '0;
          state_d     = (word_count != '0) ? READ : DONE;
        end
      end
      READ: begin
        busy       = 1'b1;
        mem_addr   = src_ptr_q;
        data_d     = mem_rd;
        checksum_d = checksum_q + mem_rd;
        state_d    = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        mem_addr    = dst_ptr_q;
        mem_wd      = data_q;
        // Gate the strobe with reset so an abandoned copy never lands its in-flight word.
        mem_we      = !reset;
        src_ptr_d   = src_ptr_q + 32'd4;
        dst_ptr_d   = dst_ptr_q + 32'd4;
        remaining_d = remaining_q - CNT_W'(1);
        state_d     = (remaining_q == CNT_W'(1)) ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign checksum = checksum_q;

endmodule

// File: tb/tb_mem_copier.sv
// Randomized and directed bench for mem_copier against a word-array reference model
// of forward memory copy with checksum.
module tb_mem_copier;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [31:0]      src_addr, dst_addr;
  logic [CNT_W-1:0] word_count;
  logic             busy, done, mem_we;
  logic [31:0]      checksum, mem_addr, mem_wd, mem_rd;

  always #5 clk = ~clk;

  mem_copier #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .word_count(word_count), .busy(busy), .done(done), .checksum(checksum),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  // Memory seen by the DUT: words written by the DUT, else preloaded words, else a fill pattern.
  logic [31:0] mem     [int unsigned];
  logic [31:0] pre_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  int          mem_ver = 0;
  int          pre_ver = 0;
  logic [31:0] wr_a[$], wr_d[$], rd_a[$];
  logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [31:0] dflt(input int unsigned idx);
    return (idx * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_mem(input int unsigned idx);
    if (mem.exists(idx)) return mem[idx];
    if (pre_mem.exists(idx)) return pre_mem[idx];
    return dflt(idx);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned idx);
    if (ref_mem.exists(idx)) return ref_mem[idx];
    return dflt(idx);
  endfunction

  always @(mem_addr or mem_ver or pre_ver) mem_rd = rd_mem(mem_addr >> 2);

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr >> 2] = mem_wd;
      wr_a.push_back(mem_addr);
      wr_d.push_back(mem_wd);
      mem_ver = mem_ver + 1;
    end else if (busy && !reset) begin
      rd_a.push_back(mem_addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    pre_mem[addr >> 2] = val;
    ref_mem[addr >> 2] = val;
    pre_ver++;
  endtask

  // Forward word copy: each word is read after all earlier words have been written.
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            output logic [31:0] cks);
    logic [31:0] sa, da, v;
    cks = 32'd0;
    exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
    for (int i = 0; i < n; i++) begin
      sa = {s[31:2], 2'b00} + 32'(4 * i);
      da = {d[31:2], 2'b00} + 32'(4 * i);
      v  = ref_rd(sa >> 2);
      ref_mem[da >> 2] = v;
      cks = cks + v;
      exp_ra.push_back(sa);
      exp_wa.push_back(da);
      exp_wd.push_back(v);
    end
  endtask

  task automatic run_copy(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input int n);
    logic [31:0] cks;
    int edges;
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    model_copy(s, d, n, cks);
    src_addr = s; dst_addr = d; word_count = CNT_W'(n); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    edges = -1;
    for (int i = 0; i < 2 * n + 10; i++) begin
      @(negedge clk);
      if (done) begin
        edges = i;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(edges), 32'(2 * n));
    chk({tag, ".checksum"}, checksum, cks);
    chk({tag, ".busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, ".done_width"}, 32'(done), 32'd0);
    chk({tag, ".checksum_hold"}, checksum, cks);
    chk({tag, ".n_writes"}, 32'(wr_a.size()), 32'(exp_wa.size()));
    chk({tag, ".n_reads"}, 32'(rd_a.size()), 32'(exp_ra.size()));
    for (int i = 0; i < exp_wa.size() && i < wr_a.size(); i++) begin
      chk($sformatf("%s.wr_addr%0d", tag, i), wr_a[i], exp_wa[i]);
      chk($sformatf("%s.wr_data%0d", tag, i), wr_d[i], exp_wd[i]);
    end
    for (int i = 0; i < exp_ra.size() && i < rd_a.size(); i++)
      chk($sformatf("%s.rd_addr%0d", tag, i), rd_a[i], exp_ra[i]);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.mem%0d", tag, i), rd_mem(exp_wa[i] >> 2), ref_rd(exp_wa[i] >> 2));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, d, keep;
    logic [31:0] cks;
    int edges, n_done;
    bit seen_done;
    reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; word_count = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wd", mem_wd, 32'd0);
    chk("rst.checksum", checksum, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    poke(32'h00, 32'h11); poke(32'h04, 32'h22); poke(32'h08, 32'h33);
    run_copy("copy3", 32'h00, 32'h40, 3);
    chk("copy3.sum66", checksum, 32'h66);

    run_copy("zero", 32'h10, 32'h50, 0);
    chk("zero.sum", checksum, 32'd0);

    run_copy("wrap", 32'hFFFF_FFFE, 32'h103, 2);
    if (rd_a.size() == 2 && wr_a.size() == 2) begin
      chk("wrap.rd0", rd_a[0], 32'hFFFF_FFFC);
      chk("wrap.rd1", rd_a[1], 32'h0000_0000);
      chk("wrap.wr0", wr_a[0], 32'h100);
      chk("wrap.wr1", wr_a[1], 32'h104);
    end else begin
      chk("wrap.access_count", 32'(rd_a.size() + wr_a.size()), 32'd4);
    end

    poke(32'h00, 32'hAAAA_0001); poke(32'h04, 32'hBBBB_0002); poke(32'h08, 32'hCCCC_0003);
    run_copy("overlap", 32'h00, 32'h04, 2);
    chk("overlap.mem4", rd_mem(32'h04 >> 2), 32'hAAAA_0001);
    chk("overlap.mem8", rd_mem(32'h08 >> 2), 32'hAAAA_0001);

    // start coinciding with reset must not launch a copy
    reset = 1'b1; start = 1'b1; src_addr = 32'h200; dst_addr = 32'h280; word_count = CNT_W'(3);
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start.busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_start.done", 32'(done), 32'd0);

    // reset during the second WRITE of a 4-word copy
    for (int i = 0; i < 4; i++) poke(32'h200 + 32'(4 * i), 32'hD00D_0000 + 32'(i));
    keep = rd_mem(32'h284 >> 2);
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    src_addr = 32'h200; dst_addr = 32'h280; word_count = CNT_W'(4); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.mem_we", 32'(mem_we), 32'd0);
    chk("abort.checksum", checksum, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort.n_writes", 32'(wr_a.size()), 32'd1);
    chk("abort.first_word", rd_mem(32'h280 >> 2), 32'hD00D_0000);
    chk("abort.second_word", rd_mem(32'h284 >> 2), keep);
    ref_mem[32'h280 >> 2] = 32'hD00D_0000;

    // start held high: the repeat copy is accepted only from IDLE after done
    for (int i = 0; i < 2; i++) poke(32'h300 + 32'(4 * i), 32'h0BAD_0000 + 32'(i));
    model_copy(32'h300, 32'h380, 2, cks);
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    src_addr = 32'h300; dst_addr = 32'h380; word_count = CNT_W'(2); start = 1'b1;
    @(posedge clk);
    edges = -1; n_done = 0; seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        seen_done = 1'b1;
      end else if (seen_done && busy) begin
        edges = i;
        break;
      end
    end
    chk("hold.reaccept_edge", 32'(edges), 32'd6);
    chk("hold.done_pulses", 32'(n_done), 32'd1);
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20 && n_done == 0; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("hold.second_done", 32'(n_done), 32'd1);
    @(negedge clk);
    chk("hold.n_writes", 32'(wr_a.size()), 32'd4);
    chk("hold.checksum", checksum, cks);

    for (int k = 0; k < 12; k++) begin
      s = 32'h400 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      d = 32'h400 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      run_copy($sformatf("rand%0d", k), s, d, int'($urandom_range(0, 6)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
